cook_sequencer: RTL and testbench
=================================

COOK_SEQUENCER -- requirements
Module: cook_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_STAGES, default 4, meaning the number of cook-program stages.
REQ-002 The block SHALL have parameter MAX_SECS, default 599, meaning the maximum stage time in seconds (9:59).
REQ-003 Port: clock  in  1  single system clock; all state changes occur on the rising edge.
REQ-004 Port: clearn  in  1  reset, asynchronous and active-low.
REQ-005 Port: sec_tick  in  1  one-cycle pulse, once per second.
REQ-006 Port: startn  in  1  start button, active-low level.
REQ-007 Port: stopn  in  1  stop button, active-low level.
REQ-008 Port: door_closed  in  1  1 = door closed.
REQ-009 Port: prog_we  in  1  stage-table write strobe.
REQ-010 Port: prog_idx  in  2  stage index to write.
REQ-011 Port: prog_secs  in  10  stage time in seconds.
REQ-012 Port: prog_power  in  4  stage power level, 0..10.
REQ-013 Port: mag_on  out  1  magnetron enable.
REQ-014 Port: remaining  out  10  seconds left in the current stage.
REQ-015 Port: stage  out  2  active stage index.
REQ-016 Port: busy  out  1  high in RUN or PAUSE.
REQ-017 Port: done  out  1  high for the 3 s end-of-cook beep.

Function
REQ-018 States SHALL be: IDLE, RUN, PAUSE, DONE.
REQ-019 startn and stopn SHALL each be registered, and a request SHALL be the 1->0 transition of the registered value; a held-low button SHALL produce exactly one request.
REQ-020 Writes:
- prog_we SHALL write the table only in IDLE; writes in any other state SHALL be ignored.
- prog_secs > MAX_SECS SHALL be stored as MAX_SECS.
- prog_power > 10 SHALL be stored as 10.
REQ-021 IDLE -> RUN on a start request only when door_closed=1 and at least one stage has nonzero time:
- load the lowest-index nonzero stage into remaining and stage;
- clear the duty phase counter.
REQ-022 A start request that fails the REQ-021 conditions SHALL be ignored, with state staying IDLE.
REQ-023 In RUN, each sec_tick SHALL decrement remaining by 1 and advance the phase counter modulo 10.
REQ-024 When remaining reaches 0 in RUN:
- on the next cycle, load the next higher-index stage with nonzero time, and clear the phase counter;
- if no such stage exists, go to DONE.
REQ-025 Stages with zero time SHALL be skipped.
REQ-026 mag_on SHALL equal (state==RUN) & door_closed & (phase < power of the current stage), computed combinationally so that a door opening drops mag_on in the same cycle.
REQ-027 Power 0 SHALL count time with mag_on=0; power 10 SHALL keep mag_on=1 for the whole stage.
REQ-028 RUN -> PAUSE on door_closed=0 or a stop request; remaining, stage and phase SHALL be held.
REQ-029 PAUSE -> RUN on a start request with door_closed=1; PAUSE -> IDLE on a stop request, clearing remaining and stage to 0.
REQ-030 DONE SHALL assert done for 3 sec_ticks, then return to IDLE; a stop request in DONE SHALL go to IDLE immediately.
REQ-031 Simultaneous events SHALL follow this priority: stop > door open > start > sec_tick.
REQ-032 A sec_tick in the same cycle as a pause transition SHALL NOT decrement remaining.
REQ-033 The stage table SHALL persist across cooks until reset.

Reset
REQ-034 On clearn=0, asynchronously:
- state = IDLE; mag_on, busy, done, remaining and stage = 0;
- phase counter, button registers and beep counter = 0;
- all table entries = 0 time and 0 power.
REQ-035 A reset asserted mid-cook SHALL take effect immediately, with mag_on low before the next clock edge.

Structure
REQ-036 A shared package microwave_pkg SHALL hold the state encoding, MAX_SECS, NUM_STAGES, MAX_POWER=10 and BEEP_SECS=3.
REQ-037 One sub-module, button_edge, SHALL perform the REQ-019 registering and falling-edge detect, instanced for startn and stopn.

Verification
REQ-038 Program stage0 = 5 s at power 10, press start with door closed -> mag_on=1 for 5 sec_ticks, remaining counts 5..0, done=1 for 3 ticks, then IDLE.
REQ-039 Program stage0 = 20 s at power 3 -> in each 10-tick window, mag_on=1 during phases 0-2 and 0 during phases 3-9.
REQ-040 Program stages 0/1/2 = 2 s P10 / 0 s / 3 s P5 -> stage goes 0 then 2, stage 1 is skipped, total 5 ticks.
REQ-041 Drop door_closed mid-RUN with remaining=7 -> mag_on=0 the same cycle, PAUSE, remaining stays 7 while ticking; close the door and press start -> RUN resumes from 7.
REQ-042 Stop and start in the same cycle during RUN -> PAUSE; a second stop -> IDLE, remaining=0.
REQ-043 Assert clearn during RUN -> all outputs 0 asynchronously; a start after release is ignored because the table is now empty.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared constants and state encoding for the microwave cook sequencer.
package microwave_pkg;

  localparam int unsigned NUM_STAGES = 4;
  localparam int unsigned MAX_SECS   = 599;
  localparam int unsigned MAX_POWER  = 10;
  localparam int unsigned BEEP_SECS  = 3;

  localparam int unsigned SECS_W  = 10;
  localparam int unsigned PWR_W   = 4;
  localparam int unsigned STAGE_W = 2;
  localparam int unsigned PHASE_W = 4;
  localparam int unsigned BEEP_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/button_edge.sv
// Registers an active-low button and flags the 1->0 transition of the
// registered level, so a held button yields a single request.
//   clock, clearn : clock and async active-low reset
//   btn_n         : raw active-low button level
//   fall_c        : one-cycle request (combinational from registers)
module button_edge (
  input  logic clock,
  input  logic clearn,
  input  logic btn_n,
  output logic fall_c
);

  logic level;
  logic level_d;

  // Two-stage capture: current registered level and its previous value.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      level   <= btn_n;
      level_d <= level;
    end
  end

  assign fall_c = level_d & ~level;

endmodule

// File: rtl/cook_sequencer.sv
// Multi-stage microwave cook sequencer: programmable stage table, second
// countdown per stage, power duty cycling over a 10-second phase window,
// pause/resume on door or stop, and a timed end-of-cook beep.
//   clock, clearn          : clock and async active-low reset
//   sec_tick               : one-cycle pulse per second
//   startn, stopn          : active-low buttons
//   door_closed            : 1 = door closed
//   prog_we/idx/secs/power : stage-table write port (accepted in IDLE only)
//   mag_on                 : magnetron enable (combinational, drops with door)
//   remaining, stage       : current stage countdown and index
//   busy, done             : RUN/PAUSE indicator, end-of-cook beep
module cook_sequencer
  import microwave_pkg::state_e, microwave_pkg::ST_IDLE, microwave_pkg::ST_RUN,
         microwave_pkg::ST_PAUSE, microwave_pkg::ST_DONE, microwave_pkg::SECS_W,
         microwave_pkg::PWR_W, microwave_pkg::STAGE_W, microwave_pkg::PHASE_W,
         microwave_pkg::BEEP_W, microwave_pkg::MAX_POWER, microwave_pkg::BEEP_SECS;
#(
  parameter int unsigned NUM_STAGES = microwave_pkg::NUM_STAGES,
  parameter int unsigned MAX_SECS   = microwave_pkg::MAX_SECS
) (
  input  logic               clock,
  input  logic               clearn,
  input  logic               sec_tick,
  input  logic               startn,
  input  logic               stopn,
  input  logic               door_closed,
  input  logic               prog_we,
  input  logic [STAGE_W-1:0] prog_idx,
  input  logic [SECS_W-1:0]  prog_secs,
  input  logic [PWR_W-1:0]   prog_power,
  output logic               mag_on,
  output logic [SECS_W-1:0]  remaining,
  output logic [STAGE_W-1:0] stage,
  output logic               busy,
  output logic               done
);

  localparam int unsigned TAB_DEPTH = 1 << STAGE_W;

  state_e               state, state_next;
  logic [SECS_W-1:0]    remaining_next;
  logic [STAGE_W-1:0]   stage_next;
  logic [PHASE_W-1:0]   phase, phase_next;
  logic [BEEP_W-1:0]    beep, beep_next;
  logic [SECS_W-1:0]    secs_tab [TAB_DEPTH];
  logic [PWR_W-1:0]     pwr_tab  [TAB_DEPTH];
  logic                 start_req_c, stop_req_c;
  logic                 first_ok, next_ok;
  logic [STAGE_W-1:0]   first_nz, next_nz;

  button_edge u_start (.clock(clock), .clearn(clearn), .btn_n(startn), .fall_c(start_req_c));
  button_edge u_stop  (.clock(clock), .clearn(clearn), .btn_n(stopn),  .fall_c(stop_req_c));

  // Lowest nonzero stage overall, and lowest nonzero stage above the current one.
  always_comb begin
    first_ok = 1'b0;
    first_nz = '0;
    next_ok  = 1'b0;
    next_nz  = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (!first_ok && secs_tab[STAGE_W'(i)] != '0) begin
        first_ok = 1'b1;
        first_nz = STAGE_W'(i);
      end
      if (!next_ok && STAGE_W'(i) > stage && secs_tab[STAGE_W'(i)] != '0) begin
        next_ok = 1'b1;
        next_nz = STAGE_W'(i);
      end
    end
  end

  // Next-state logic; priority is stop > door open > start > sec_tick.
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    stage_next     = stage;
    phase_next     = phase;
    beep_next      = beep;
    case (state)
      ST_IDLE: begin
        if (!stop_req_c && start_req_c && door_closed && first_ok) begin
          state_next     = ST_RUN;
          remaining_next = secs_tab[first_nz];
          stage_next     = first_nz;
          phase_next     = '0;
        end
      end
      ST_RUN: begin
        if (stop_req_c || !door_closed) begin
          state_next = ST_PAUSE;
        end else if (remaining == '0) begin
          if (next_ok) begin
            remaining_next = secs_tab[next_nz];
            stage_next     = next_nz;
            phase_next     = '0;
          end else begin
            state_next = ST_DONE;
            beep_next  = '0;
          end
        end else if (sec_tick) begin
          remaining_next = remaining - 1'b1;
          phase_next     = (phase == PHASE_W'(MAX_POWER - 1)) ? '0 : phase + 1'b1;
        end
      end
      ST_PAUSE: begin
        if (stop_req_c) begin
          state_next     = ST_IDLE;
          remaining_next = '0;
          stage_next     = '0;
          phase_next     = '0;
        end else if (start_req_c && door_closed) begin
          state_next = ST_RUN;
        end
      end
      ST_DONE: begin
        if (stop_req_c) begin
          state_next = ST_IDLE;
          stage_next = '0;
          beep_next  = '0;
        end else if (sec_tick) begin
          if (beep == BEEP_W'(BEEP_SECS - 1)) begin
            state_next = ST_IDLE;
            stage_next = '0;
            beep_next  = '0;
          end else begin
            beep_next = beep + 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, datapath and stage-table registers.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      state     <= ST_IDLE;
      remaining <= '0;
      stage     <= '0;
      phase     <= '0;
      beep      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int unsigned i = 0; i < TAB_DEPTH; i++) begin
        secs_tab[STAGE_W'(i)] <= '0;
        pwr_tab[STAGE_W'(i)]  <= '0;
      end
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      stage     <= stage_next;
      phase     <= phase_next;
      beep      <= beep_next;
      busy      <= (state_next == ST_RUN) || (state_next == ST_PAUSE);
      done      <= (state_next == ST_DONE);
      if (state == ST_IDLE && prog_we) begin
        secs_tab[prog_idx] <= (prog_secs > SECS_W'(MAX_SECS)) ? SECS_W'(MAX_SECS) : prog_secs;
        pwr_tab[prog_idx]  <= (prog_power > PWR_W'(MAX_POWER)) ? PWR_W'(MAX_POWER) : prog_power;
      end
    end
  end

  // Combinational so that opening the door or resetting drops the magnetron at once.
  assign mag_on = (state == ST_RUN) & door_closed & (phase < pwr_tab[stage]);

endmodule

// File: tb/tb_cook_sequencer.sv
// Self-checking bench for cook_sequencer against a cook-timeline model.
module tb_cook_sequencer;

  logic       clock = 1'b0;
  logic       clearn = 1'b1;
  logic       sec_tick = 1'b0;
  logic       startn = 1'b1;
  logic       stopn = 1'b1;
  logic       door_closed = 1'b1;
  logic       prog_we = 1'b0;
  logic [1:0] prog_idx = '0;
  logic [9:0] prog_secs = '0;
  logic [3:0] prog_power = '0;
  logic       mag_on;
  logic [9:0] remaining;
  logic [1:0] stage;
  logic       busy;
  logic       done;

  int total = 0;
  int bad = 0;
  int m_secs[4];
  int m_pwr[4];

  cook_sequencer dut (
    .clock(clock), .clearn(clearn), .sec_tick(sec_tick), .startn(startn),
    .stopn(stopn), .door_closed(door_closed), .prog_we(prog_we),
    .prog_idx(prog_idx), .prog_secs(prog_secs), .prog_power(prog_power),
    .mag_on(mag_on), .remaining(remaining), .stage(stage), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic press_start();
    startn = 1'b0; step(); startn = 1'b1; step();
  endtask

  task automatic press_stop();
    stopn = 1'b0; step(); stopn = 1'b1; step();
  endtask

  task automatic press_both();
    startn = 1'b0; stopn = 1'b0; step(); startn = 1'b1; stopn = 1'b1; step();
  endtask

  task automatic tick();
    sec_tick = 1'b1; step(); sec_tick = 1'b0;
  endtask

  task automatic program_stage(input int idx, input int secs, input int pwr, input bit stored);
    prog_we = 1'b1; prog_idx = 2'(idx); prog_secs = 10'(secs); prog_power = 4'(pwr);
    step();
    prog_we = 1'b0;
    if (stored) begin
      m_secs[idx] = (secs > 599) ? 599 : secs;
      m_pwr[idx]  = (pwr > 10) ? 10 : pwr;
    end
  endtask

  task automatic program_all(input int s0, input int p0, input int s1, input int p1,
                             input int s2, input int p2, input int s3, input int p3);
    program_stage(0, s0, p0, 1'b1);
    program_stage(1, s1, p1, 1'b1);
    program_stage(2, s2, p2, 1'b1);
    program_stage(3, s3, p3, 1'b1);
  endtask

  // Full cook from IDLE: each nonzero stage in index order counts down its
  // seconds with mag_on following (seconds elapsed mod 10) < power, then beep.
  task automatic run_cook(input bit scribble);
    int order[$];
    int idx, t, p;
    logic exp_mag;
    for (int i = 0; i < 4; i++) if (m_secs[i] > 0) order.push_back(i);
    press_start();
    if (order.size() == 0) begin
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL empty_start: busy=%0b exp 0", busy); end
    end else begin
      foreach (order[n]) begin
        idx = order[n]; t = m_secs[idx]; p = m_pwr[idx];
        exp_mag = (p > 0);
        total++;
        if (remaining !== 10'(t) || stage !== 2'(idx) || busy !== 1'b1 || mag_on !== exp_mag) begin
          bad++;
          $display("FAIL stage_load: rem=%0d stage=%0d busy=%0b mag=%0b exp rem=%0d stage=%0d busy=1 mag=%0b",
                   remaining, stage, busy, mag_on, t, idx, exp_mag);
        end
        for (int k = 1; k <= t; k++) begin
          tick();
          exp_mag = ((k % 10) < p);
          total++;
          if (remaining !== 10'(t - k) || stage !== 2'(idx) || mag_on !== exp_mag) begin
            bad++;
            $display("FAIL countdown: stage=%0d k=%0d rem=%0d mag=%0b exp rem=%0d mag=%0b",
                     idx, k, remaining, mag_on, t - k, exp_mag);
          end
          if (scribble) begin
            prog_we = 1'b1; prog_idx = 2'($urandom);
            prog_secs = 10'($urandom); prog_power = 4'($urandom);
          end
          step();
          prog_we = 1'b0;
        end
      end
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || mag_on !== 1'b0 || remaining !== 10'd0) begin
        bad++;
        $display("FAIL done_entry: done=%0b busy=%0b mag=%0b rem=%0d exp 1 0 0 0", done, busy, mag_on, remaining);
      end
      for (int b = 1; b <= 3; b++) begin
        tick();
        total++;
        if (done !== (b < 3) || busy !== 1'b0) begin
          bad++;
          $display("FAIL beep: tick=%0d done=%0b busy=%0b exp done=%0b busy=0", b, done, busy, b < 3);
        end
        step();
      end
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || remaining !== 10'd0 || mag_on !== 1'b0) begin
        bad++;
        $display("FAIL back_idle: done=%0b busy=%0b rem=%0d mag=%0b exp all 0", done, busy, remaining, mag_on);
      end
    end
  endtask

  task automatic test_reset();
    #1 clearn = 1'b0;
    #2;
    total++;
    if (mag_on !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || remaining !== 10'd0 || stage !== 2'd0) begin
      bad++;
      $display("FAIL reset: mag=%0b busy=%0b done=%0b rem=%0d stage=%0d exp all 0",
               mag_on, busy, done, remaining, stage);
    end
    step(); step();
    #2 clearn = 1'b1;
    step(); step(); step();
  endtask

  task automatic test_power10();
    program_all(5, 10, 0, 0, 0, 0, 0, 0);
    run_cook(1'b0);
  endtask

  task automatic test_power3();
    program_all(20, 3, 0, 0, 0, 0, 0, 0);
    run_cook(1'b0);
  endtask

  task automatic test_skip();
    program_all(2, 10, 0, 7, 3, 5, 0, 0);
    run_cook(1'b0);
  endtask

  task automatic test_door_gating();
    program_all(4, 10, 0, 0, 0, 0, 0, 0);
    door_closed = 1'b0;
    press_start();
    total++;
    if (busy !== 1'b0 || mag_on !== 1'b0) begin
      bad++; $display("FAIL door_gate: busy=%0b mag=%0b exp 0 0", busy, mag_on);
    end
    door_closed = 1'b1;
    step();
  endtask

  task automatic test_door_pause();
    program_all(10, 10, 0, 0, 0, 0, 0, 0);
    press_start();
    for (int k = 0; k < 3; k++) begin tick(); step(); end
    total++;
    if (remaining !== 10'd7 || mag_on !== 1'b1) begin
      bad++; $display("FAIL pre_door: rem=%0d mag=%0b exp 7 1", remaining, mag_on);
    end
    door_closed = 1'b0;
    #1;
    total++;
    if (mag_on !== 1'b0) begin bad++; $display("FAIL door_same_cycle: mag=%0b exp 0", mag_on); end
    tick();
    total++;
    if (remaining !== 10'd7 || busy !== 1'b1 || mag_on !== 1'b0) begin
      bad++; $display("FAIL pause_tick: rem=%0d busy=%0b mag=%0b exp 7 1 0", remaining, busy, mag_on);
    end
    tick(); step();
    door_closed = 1'b1;
    #1;
    total++;
    if (remaining !== 10'd7 || mag_on !== 1'b0) begin
      bad++; $display("FAIL paused_closed: rem=%0d mag=%0b exp 7 0", remaining, mag_on);
    end
    press_start();
    total++;
    if (remaining !== 10'd7 || mag_on !== 1'b1 || busy !== 1'b1 || stage !== 2'd0) begin
      bad++; $display("FAIL resume: rem=%0d mag=%0b busy=%0b stage=%0d exp 7 1 1 0", remaining, mag_on, busy, stage);
    end
    tick();
    total++;
    if (remaining !== 10'd6) begin bad++; $display("FAIL resume_tick: rem=%0d exp 6", remaining); end
    step();
    press_stop(); press_stop();
    total++;
    if (remaining !== 10'd0 || busy !== 1'b0 || stage !== 2'd0) begin
      bad++; $display("FAIL stop_idle: rem=%0d busy=%0b stage=%0d exp 0 0 0", remaining, busy, stage);
    end
  endtask

  task automatic test_stop_start();
    program_all(8, 10, 0, 0, 0, 0, 0, 0);
    press_start();
    tick(); step();
    press_both();
    total++;
    if (busy !== 1'b1 || mag_on !== 1'b0 || remaining !== 10'd7) begin
      bad++; $display("FAIL both_pause: busy=%0b mag=%0b rem=%0d exp 1 0 7", busy, mag_on, remaining);
    end
    press_stop();
    total++;
    if (busy !== 1'b0 || remaining !== 10'd0 || mag_on !== 1'b0) begin
      bad++; $display("FAIL second_stop: busy=%0b rem=%0d mag=%0b exp 0 0 0", busy, remaining, mag_on);
    end
  endtask

  task automatic test_done_stop();
    program_all(1, 10, 0, 0, 0, 0, 0, 0);
    press_start();
    tick(); step();
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL done_reach: done=%0b exp 1", done); end
    press_stop();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL done_stop: done=%0b busy=%0b exp 0 0", done, busy);
    end
  endtask

  task automatic test_clamp_persist();
    program_all(1000, 12, 0, 0, 0, 0, 0, 0);
    press_start();
    total++;
    if (remaining !== 10'd599 || mag_on !== 1'b1) begin
      bad++; $display("FAIL clamp: rem=%0d mag=%0b exp 599 1", remaining, mag_on);
    end
    press_stop();
    program_stage(0, 2, 5, 1'b0);
    press_stop();
    press_start();
    total++;
    if (remaining !== 10'(m_secs[0]) || busy !== 1'b1) begin
      bad++; $display("FAIL persist: rem=%0d busy=%0b exp %0d 1", remaining, busy, m_secs[0]);
    end
    press_stop(); press_stop();
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++)
        program_stage(i, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6)),
                      int'($urandom_range(0, 15)), 1'b1);
      run_cook(1'b1);
    end
  endtask

  task automatic test_async_reset();
    program_all(9, 10, 0, 0, 0, 0, 0, 0);
    press_start();
    tick(); step();
    total++;
    if (mag_on !== 1'b1) begin bad++; $display("FAIL pre_reset: mag=%0b exp 1", mag_on); end
    #2 clearn = 1'b0;
    #1;
    total++;
    if (mag_on !== 1'b0 || busy !== 1'b0 || remaining !== 10'd0 || stage !== 2'd0 || done !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: mag=%0b busy=%0b rem=%0d stage=%0d done=%0b exp all 0",
               mag_on, busy, remaining, stage, done);
    end
    for (int i = 0; i < 4; i++) begin m_secs[i] = 0; m_pwr[i] = 0; end
    step();
    #2 clearn = 1'b1;
    step(); step(); step();
    press_start();
    total++;
    if (busy !== 1'b0 || mag_on !== 1'b0 || remaining !== 10'd0) begin
      bad++; $display("FAIL empty_after_reset: busy=%0b mag=%0b rem=%0d exp 0 0 0", busy, mag_on, remaining);
    end
  endtask

  initial begin
    test_reset();
    test_power10();
    test_power3();
    test_skip();
    test_door_gating();
    test_door_pause();
    test_stop_start();
    test_done_stop();
    test_clamp_persist();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
